sram_rr_ctrl: RTL and testbench

- Two-requester round-robin controller in front of one single-port OpenRAM macro top (active-low csb0/web0, one-cycle read latency).
- Serialises requests, drives the macro command pins from registers and returns read data tagged to the requester that issued it.
- After reset, optionally scrubs every word to INIT_VALUE before accepting traffic.
- Sits between the core-side requesters and the banked SRAM top.

---
 rtl/sram_rr_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter_2.sv | 44 ++++
 rtl/sram_rr_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_rr_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rr_ctrl_pkg.sv
// Shared types for the two-requester SRAM controller.
//   state_e   : controller phase (scrub sweep, then normal traffic)
//   REQ0/REQ1 : requester identifiers carried with each read
//   rsp_ent_t : one response-pipe stage {is_read, id}
package sram_rr_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef struct packed {
    logic is_read;
    logic id;
  } rsp_ent_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   en_i                 : arbitration enabled (grants forced low otherwise)
//   valid0_i, valid1_i   : requester valids
//   gnt0_c_o, gnt1_c_o   : combinational one-hot grants
module rr_arbiter_2
  import sram_rr_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic gnt0_c_o,
  output logic gnt1_c_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection; the pointer moves only when both requesters compete.
  always_comb begin
    gnt0_c_o = 1'b0;
    gnt1_c_o = 1'b0;
    ptr_d    = ptr_q;
    if (en_i) begin
      if (valid0_i && valid1_i) begin
        if (ptr_q == REQ0) gnt0_c_o = 1'b1;
        else               gnt1_c_o = 1'b1;
        ptr_d = ~ptr_q;
      end else begin
        gnt0_c_o = valid0_i;
        gnt1_c_o = valid1_i;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= REQ0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Round-robin front end for one single-port OpenRAM macro.
//   clk0, rst0            : clock (shared with macro), synchronous active-high reset
//   reqN_valid/ready      : command handshake per requester (ready is combinational)
//   reqN_we/addr/wdata    : command payload
//   rsp0_valid/rsp1_valid : one-cycle read-response pulses, tagged per requester
//   rsp_rdata             : registered read data, held between pulses
//   init_done             : high once the scrub sweep is finished
//   sram_*                : registered macro command pins, sram_dout0 is macro read data
module sram_rr_ctrl
  import sram_rr_ctrl_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH    = 2,
  parameter int unsigned             ADDR_WIDTH    = 4,
  parameter bit                      INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE    = '0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  csb_q, web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  rsp_ent_t [1:0]        pipe_q;
  logic                  rsp0_q, rsp1_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  init_done_q;

  logic                  run_c;
  logic                  gnt0_c, gnt1_c;
  logic                  acc0_c, acc1_c, acc_c;
  logic                  sel_id_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;

  // Readies are held low during reset and during the scrub.
  assign run_c = (state_q == ST_RUN) && !rst0;

  rr_arbiter_2 u_arb (
    .clk_i    (clk0),
    .rst_i    (rst0),
    .en_i     (run_c),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .gnt0_c_o (gnt0_c),
    .gnt1_c_o (gnt1_c)
  );

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // Accepted-command mux; grants are one-hot so requester 1 wins the select only when granted.
  always_comb begin
    acc0_c      = req0_valid & gnt0_c;
    acc1_c      = req1_valid & gnt1_c;
    acc_c       = acc0_c | acc1_c;
    sel_id_c    = acc1_c ? REQ1 : REQ0;
    sel_we_c    = acc1_c ? req1_we    : req0_we;
    sel_addr_c  = acc1_c ? req1_addr  : req0_addr;
    sel_wdata_c = acc1_c ? req1_wdata : req0_wdata;
  end

  // FSM, scrub counter, macro command registers and response pipe.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      pipe_q      <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          csb_q     <= 1'b0;
          web_q     <= 1'b0;
          addr_q    <= cnt_q;
          din_q     <= INIT_VALUE;
          cnt_q     <= cnt_q + ADDR_WIDTH'(1);
          pipe_q[0] <= '0;
          if (cnt_q == LAST_ADDR) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          init_done_q <= 1'b1;
          if (acc_c) begin
            csb_q  <= 1'b0;
            web_q  <= ~sel_we_c;
            addr_q <= sel_addr_c;
            din_q  <= sel_wdata_c;
          end else begin
            csb_q <= 1'b1;
            web_q <= 1'b1;
          end
          pipe_q[0] <= '{is_read: acc_c & ~sel_we_c, id: sel_id_c};
        end
      endcase

      // Stage 1 lines up with macro dout one cycle after the macro sampled the read.
      pipe_q[1] <= pipe_q[0];
      rsp0_q    <= pipe_q[1].is_read && (pipe_q[1].id == REQ0);
      rsp1_q    <= pipe_q[1].is_read && (pipe_q[1].id == REQ1);
      if (pipe_q[1].is_read) rdata_q <= sram_dout0;
    end
  end

  assign sram_csb0  = csb_q;
  assign sram_web0  = web_q;
  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_rdata  = rdata_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Directed bench for sram_rr_ctrl with a behavioural one-cycle-latency SRAM.
module tb_sram_rr_ctrl;

  logic       clk0 = 1'b0;
  logic       rst0;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [1:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [1:0] req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [1:0] rsp_rdata;
  logic       init_done;
  logic       sram_csb0, sram_web0;
  logic [3:0] sram_addr0;
  logic [1:0] sram_din0;
  logic [1:0] sram_dout0;

  logic [1:0] mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  sram_rr_ctrl #(
    .DATA_WIDTH(2), .ADDR_WIDTH(4), .INIT_ON_RESET(1'b1), .INIT_VALUE(2'b00)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Behavioural macro: samples pins on the edge, read data appears after that edge.
  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  // Present one command and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic id, input logic we, input logic [3:0] a, input logic [1:0] d);
    int n = 0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL issue_timeout: requester %0d not accepted after %0d cycles", id, n);
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step(); step();
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_pins: got csb=%b web=%b addr=%0d din=%0d expected 1 1 0 0",
               sram_csb0, sram_web0, sram_addr0, sram_din0);
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata, init_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rsp0=%b rsp1=%b rdata=%0d done=%b expected all 0",
               rsp0_valid, rsp1_valid, rsp_rdata, init_done);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
  endtask

  task automatic test_scrub();
    rst0 = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b0, 1'b0, 4'(i), 2'b00}) begin
        errors++;
        $display("FAIL scrub_word%0d: got csb=%b web=%b addr=%0d din=%0d expected 0 0 %0d 0",
                 i, sram_csb0, sram_web0, sram_addr0, sram_din0, i);
      end
      if (i < 15) begin
        checks++;
        if (req0_ready !== 1'b0 || init_done !== 1'b0) begin
          errors++;
          $display("FAIL scrub_busy%0d: got ready0=%b done=%b expected 0 0", i, req0_ready, init_done);
        end
      end
      if (i == 14) req0_valid = 1'b0;
    end
    step();
    checks++;
    if ({init_done, sram_csb0, sram_web0} !== 3'b111) begin
      errors++;
      $display("FAIL scrub_end: got done=%b csb=%b web=%b expected 1 1 1", init_done, sram_csb0, sram_web0);
    end
    issue(1'b0, 1'b0, 4'd5, 2'b00);
    step(); step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata} !== 4'b1000) begin
      errors++;
      $display("FAIL scrub_read5: got rsp0=%b rsp1=%b rdata=%0d expected 1 0 0", rsp0_valid, rsp1_valid, rsp_rdata);
    end
    issue(1'b1, 1'b0, 4'd15, 2'b00);
    step(); step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata} !== 4'b0100) begin
      errors++;
      $display("FAIL scrub_read15: got rsp0=%b rsp1=%b rdata=%0d expected 0 1 0", rsp0_valid, rsp1_valid, rsp_rdata);
    end
  endtask

  task automatic test_write_read();
    issue(1'b0, 1'b1, 4'd3, 2'b10);
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0, sram_din0} !== {1'b0, 1'b0, 4'd3, 2'b10}) begin
      errors++;
      $display("FAIL wr_cmd: got csb=%b web=%b addr=%0d din=%0d expected 0 0 3 2",
               sram_csb0, sram_web0, sram_addr0, sram_din0);
    end
    issue(1'b0, 1'b0, 4'd3, 2'b00);
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0} !== {1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL rd_cmd: got csb=%b web=%b addr=%0d expected 0 1 3", sram_csb0, sram_web0, sram_addr0);
    end
    step();
    checks++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rd_early: got rsp0=%b rsp1=%b expected 0 0", rsp0_valid, rsp1_valid);
    end
    step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata} !== 4'b1010) begin
      errors++;
      $display("FAIL rd_rsp: got rsp0=%b rsp1=%b rdata=%0d expected 1 0 2", rsp0_valid, rsp1_valid, rsp_rdata);
    end
    step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata} !== 4'b0010) begin
      errors++;
      $display("FAIL rd_hold: got rsp0=%b rsp1=%b rdata=%0d expected 0 0 2", rsp0_valid, rsp1_valid, rsp_rdata);
    end
  endtask

  task automatic test_contention();
    issue(1'b0, 1'b1, 4'd1, 2'b01);
    issue(1'b1, 1'b1, 4'd2, 2'b11);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 4'd1;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd2;
    #1;
    for (int w = 0; w <= 6; w++) begin
      if (w > 0) step();
      if (w == 4) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
      end
      if (w < 4) begin
        checks++;
        if ({req0_ready, req1_ready} !== ((w % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL cont_grant%0d: got ready=%b%b expected %s", w, req0_ready, req1_ready,
                   (w % 2 == 0) ? "10" : "01");
        end
      end
      if (w >= 3) begin
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp_rdata} !== (((w - 3) % 2 == 0) ? 4'b1001 : 4'b0111)) begin
          errors++;
          $display("FAIL cont_rsp%0d: got rsp0=%b rsp1=%b rdata=%0d expected %s", w,
                   rsp0_valid, rsp1_valid, rsp_rdata, ((w - 3) % 2 == 0) ? "1 0 1" : "0 1 3");
        end
      end else if (w > 0) begin
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
          errors++;
          $display("FAIL cont_quiet%0d: got rsp0=%b rsp1=%b expected 0 0", w, rsp0_valid, rsp1_valid);
        end
      end
    end
  endtask

  task automatic test_write_then_read();
    issue(1'b1, 1'b1, 4'd7, 2'b11);
    issue(1'b1, 1'b0, 4'd7, 2'b00);
    step(); step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_rdata} !== 4'b0111) begin
      errors++;
      $display("FAIL wtr_rsp: got rsp0=%b rsp1=%b rdata=%0d expected 0 1 3", rsp0_valid, rsp1_valid, rsp_rdata);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({sram_csb0, sram_web0, rsp0_valid, rsp1_valid} !== 4'b1100) begin
        errors++;
        $display("FAIL idle%0d: got csb=%b web=%b rsp0=%b rsp1=%b expected 1 1 0 0",
                 i, sram_csb0, sram_web0, rsp0_valid, rsp1_valid);
      end
    end
    // Four contested grants earlier return the pointer to requester 0.
    req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 1'b0; req1_we = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL idle_ptr: got ready=%b%b expected 10", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    issue(1'b0, 1'b0, 4'd5, 2'b00);
    rst0 = 1'b1;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({sram_csb0, rsp0_valid, rsp1_valid, req0_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL rst_flight%0d: got csb=%b rsp0=%b rsp1=%b ready0=%b expected 1 0 0 0",
                 i, sram_csb0, rsp0_valid, rsp1_valid, req0_ready);
      end
    end
    req0_valid = 1'b0;
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({sram_csb0, sram_addr0, rsp0_valid} !== {1'b0, 4'(i), 1'b0}) begin
        errors++;
        $display("FAIL rst_rescrub%0d: got csb=%b addr=%0d rsp0=%b expected 0 %0d 0",
                 i, sram_csb0, sram_addr0, rsp0_valid, i);
      end
    end
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    step();
    checks++;
    if ({sram_csb0, sram_web0, sram_addr0} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rst_restart: got csb=%b web=%b addr=%0d expected 0 0 0", sram_csb0, sram_web0, sram_addr0);
    end
    while (!init_done && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (init_done !== 1'b1 || n !== 15) begin
      errors++;
      $display("FAIL rst_done: got done=%b after %0d cycles expected 1 after 15", init_done, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b10;
    sram_dout0 = 2'b00;
    rst0 = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    test_reset();
    test_scrub();
    test_write_read();
    test_contention();
    test_write_then_read();
    test_idle();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
